// File: rtl/riscv_axi_rd_arb.sv
// AXI4 read-channel arbiter: N upstream read ports share one downstream port.
// ARIDs are remapped to 0 downstream; an in-order FIFO routes R beats back.

package axi4_pkg;
    localparam int ID_W = 4;

    typedef struct packed {
        logic            arvalid;
        logic [ID_W-1:0] arid;
        logic [31:0]     araddr;
        logic [7:0]      arlen;
        logic [2:0]      arsize;
        logic [1:0]      arburst;
    } ar_m;

    typedef struct packed {
        logic arready;
    } ar_s;

    typedef struct packed {
        logic rready;
    } r_m;

    typedef struct packed {
        logic            rvalid;
        logic [ID_W-1:0] rid;
        logic [31:0]     rdata;
        logic [1:0]      rresp;
        logic            rlast;
    } r_s;
endpackage

module riscv_axi_rd_arb #(
    parameter int N_PORTS = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  axi4_pkg::ar_m [N_PORTS-1:0]  UP_AR_M,
    output axi4_pkg::ar_s [N_PORTS-1:0]  UP_AR_S,
    input  axi4_pkg::r_m  [N_PORTS-1:0]  UP_R_M,
    output axi4_pkg::r_s  [N_PORTS-1:0]  UP_R_S,
    output axi4_pkg::ar_m                DN_AR_M,
    input  axi4_pkg::ar_s                DN_AR_S,
    input  axi4_pkg::r_s                 DN_R_S,
    output axi4_pkg::r_m                 DN_R_M,
    output logic                         ORPHAN_ERR
);
    localparam int GW = $clog2(N_PORTS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                    state_q, state_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_grant_q, last_grant_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      orphan_q, orphan_d;
    logic [GW-1:0]             port_mem_q [DEPTH];
    logic [axi4_pkg::ID_W-1:0] id_mem_q   [DEPTH];

    logic          found;
    logic [GW-1:0] win;
    logic [GW-1:0] head;
    logic          fifo_empty, fifo_full, push, pop, dn_rready;
    int            idx;

    // Round-robin search begins just past the last port that won a handshake.
    always_comb begin
        found = 1'b0;
        win   = last_grant_q;
        idx   = 0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(last_grant_q) + k) % N_PORTS;
            if (!found && UP_AR_M[GW'(idx)].arvalid) begin
                win   = GW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CW'(DEPTH));
        head       = port_mem_q[rd_ptr_q];
        dn_rready  = !fifo_empty && UP_R_M[head].rready;
        push       = (state_q == ISSUE) && DN_AR_S.arready;
        pop        = !fifo_empty && DN_R_S.rvalid && dn_rready && DN_R_S.rlast;

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (found && !fifo_full) begin
                state_d = ISSUE;
                grant_d = win;
            end
        end else if (push) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        orphan_d = orphan_q | (fifo_empty & DN_R_S.rvalid);
    end

    always_comb begin
        DN_AR_M = '0;
        UP_AR_S = '0;
        if (state_q == ISSUE) begin
            DN_AR_M                 = UP_AR_M[grant_q];
            DN_AR_M.arvalid         = 1'b1;
            DN_AR_M.arid            = '0;
            UP_AR_S[grant_q].arready = DN_AR_S.arready;
        end
    end

    // Orphan beats are never accepted so memory cannot run ahead of tracking.
    always_comb begin
        UP_R_S        = '0;
        DN_R_M        = '0;
        DN_R_M.rready = dn_rready;
        if (!fifo_empty) begin
            UP_R_S[head]     = DN_R_S;
            UP_R_S[head].rid = id_mem_q[rd_ptr_q];
        end
    end

    assign ORPHAN_ERR = orphan_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_PORTS - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            orphan_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            orphan_q     <= orphan_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            port_mem_q[wr_ptr_q] <= grant_q;
            id_mem_q[wr_ptr_q]   <= UP_AR_M[grant_q].arid;
        end
    end
endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Directed bench for riscv_axi_rd_arb; expectations go into queues and a
// negedge monitor checks every downstream AR and upstream R handshake.
module tb_riscv_axi_rd_arb;
    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    axi4_pkg::ar_m [1:0] up_ar_m;
    axi4_pkg::ar_s [1:0] up_ar_s;
    axi4_pkg::r_m  [1:0] up_r_m;
    axi4_pkg::r_s  [1:0] up_r_s;
    axi4_pkg::ar_m       dn_ar_m;
    axi4_pkg::ar_s       dn_ar_s;
    axi4_pkg::r_s        dn_r_s;
    axi4_pkg::r_m        dn_r_m;
    logic                orphan;

    riscv_axi_rd_arb #(.N_PORTS(2), .DEPTH(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .UP_AR_M(up_ar_m), .UP_AR_S(up_ar_s), .UP_R_M(up_r_m), .UP_R_S(up_r_s),
        .DN_AR_M(dn_ar_m), .DN_AR_S(dn_ar_s), .DN_R_S(dn_r_s), .DN_R_M(dn_r_m),
        .ORPHAN_ERR(orphan)
    );

    // mode: 0 no timing check, 1 two cycles after previous AR, 2 two cycles after last pop
    typedef struct { int port; logic [31:0] addr; int mode; } ar_exp_t;
    typedef struct { int port; logic [3:0] rid; logic [31:0] data; logic last; } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ar_cyc  = 0;
    int last_pop_cyc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ar_exp_t mk_ar(input int p, input logic [31:0] a, input int m);
        ar_exp_t e;
        e.port = p; e.addr = a; e.mode = m;
        return e;
    endfunction

    function automatic r_exp_t mk_r(input int p, input logic [3:0] id, input logic [31:0] d, input logic l);
        r_exp_t e;
        e.port = p; e.rid = id; e.data = d; e.last = l;
        return e;
    endfunction

    always @(negedge ACLK) begin
        ar_exp_t ea;
        r_exp_t  er;
        if (ARESETn) begin
            if (dn_ar_m.arvalid && dn_ar_s.arready) begin
                if (ar_q.size() == 0) chk("ar_unexpected", ar_q.size(), 1);
                else begin
                    ea = ar_q.pop_front();
                    chk("ar_addr", dn_ar_m.araddr, ea.addr);
                    chk("ar_id", {28'd0, dn_ar_m.arid}, 0);
                    chk("ar_port_ready", up_ar_s[1'(ea.port)].arready, 1);
                    chk("ar_other_ready", up_ar_s[1'(1 - ea.port)].arready, 0);
                    if (ea.mode == 1) chk("ar_gap", cyc - last_ar_cyc, 2);
                    if (ea.mode == 2) chk("ar_after_pop", cyc - last_pop_cyc, 2);
                    last_ar_cyc = cyc;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (up_r_s[1'(p)].rvalid && up_r_m[1'(p)].rready) begin
                    if (r_q.size() == 0) chk("r_unexpected", r_q.size(), 1);
                    else begin
                        er = r_q.pop_front();
                        chk("r_port", p, er.port);
                        chk("r_rid", {28'd0, up_r_s[1'(p)].rid}, {28'd0, er.rid});
                        chk("r_data", up_r_s[1'(p)].rdata, er.data);
                        chk("r_last", up_r_s[1'(p)].rlast, er.last);
                    end
                end
            end
            if (dn_r_m.rready && dn_r_s.rvalid && dn_r_s.rlast) last_pop_cyc = cyc;
        end
    end

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic send_ar(input int p, input logic [3:0] id, input logic [31:0] addr);
        int n = 0;
        up_ar_m[1'(p)].arvalid = 1'b1;
        up_ar_m[1'(p)].arid    = id;
        up_ar_m[1'(p)].araddr  = addr;
        up_ar_m[1'(p)].arlen   = 8'd0;
        @(negedge ACLK);
        while (!up_ar_s[1'(p)].arready && n < 200) begin
            n++;
            @(negedge ACLK);
        end
        if (n >= 200) chk("ar_timeout", n, 0);
        @(posedge ACLK); #1;
        up_ar_m[1'(p)].arvalid = 1'b0;
    endtask

    task automatic send_r(input logic [31:0] d, input logic last, input int quiet);
        int n = 0;
        dn_r_s.rvalid = 1'b1;
        dn_r_s.rid    = 4'hF;
        dn_r_s.rdata  = d;
        dn_r_s.rresp  = 2'b00;
        dn_r_s.rlast  = last;
        @(negedge ACLK);
        while (!dn_r_m.rready && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (n >= 50) chk("r_timeout", n, 0);
        if (quiet >= 0) chk("r_quiet_port", up_r_s[1'(quiet)].rvalid, 0);
        @(posedge ACLK); #1;
        dn_r_s.rvalid = 1'b0;
        dn_r_s.rlast  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dn_arvalid"}, dn_ar_m.arvalid, 0);
        chk({tag, "_up_arready"}, {up_ar_s[1].arready, up_ar_s[0].arready}, 0);
        chk({tag, "_up_rvalid"}, {up_r_s[1].rvalid, up_r_s[0].rvalid}, 0);
        chk({tag, "_dn_rready"}, dn_r_m.rready, 0);
        chk({tag, "_orphan"}, orphan, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        ARESETn = 1'b0;
        up_ar_m = '0;
        up_r_m[0].rready = 1'b1;
        up_r_m[1].rready = 1'b1;
        dn_ar_s.arready  = 1'b1;
        dn_r_s = '0;
        #2 chk_all_zero("reset");
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK) chk_all_zero("post_reset");
        @(posedge ACLK); #1;

        // single AR, 4-beat burst with ID restored on the way back
        ar_q.push_back(mk_ar(0, 32'h100, 0));
        up_ar_m[0].arvalid = 1'b1;
        up_ar_m[0].arid    = 4'd3;
        up_ar_m[0].araddr  = 32'h100;
        up_ar_m[0].arlen   = 8'd3;
        @(negedge ACLK) chk("t30_idle_arvalid", dn_ar_m.arvalid, 0);
        @(negedge ACLK) chk("t30_issue_arvalid", dn_ar_m.arvalid, 1);
        @(posedge ACLK); #1 up_ar_m[0].arvalid = 1'b0;
        for (int i = 0; i < 4; i++) r_q.push_back(mk_r(0, 4'd3, 32'hD000 + i, i == 3));
        for (int i = 0; i < 4; i++) send_r(32'hD000 + i, i == 3, 1);
        @(negedge ACLK) chk("t30_no_orphan", orphan, 0);

        // fresh reset so round-robin starts from port 0
        @(posedge ACLK); #1 ARESETn = 1'b0;
        @(posedge ACLK); #1 ARESETn = 1'b1;
        ar_q.push_back(mk_ar(0, 32'h200, 0));
        ar_q.push_back(mk_ar(1, 32'h300, 1));
        ar_q.push_back(mk_ar(0, 32'h204, 1));
        ar_q.push_back(mk_ar(1, 32'h304, 1));
        fork
            begin send_ar(0, 4'd1, 32'h200); send_ar(0, 4'd2, 32'h204); end
            begin send_ar(1, 4'd5, 32'h300); send_ar(1, 4'd6, 32'h304); end
        join
        r_q.push_back(mk_r(0, 4'd1, 32'hA0, 1'b1));
        r_q.push_back(mk_r(1, 4'd5, 32'hA1, 1'b1));
        r_q.push_back(mk_r(0, 4'd2, 32'hA2, 1'b1));
        r_q.push_back(mk_r(1, 4'd6, 32'hA3, 1'b1));
        for (int i = 0; i < 4; i++) send_r(32'hA0 + i, 1'b1, -1);

        // grant held on port 1 while downstream stalls
        dn_ar_s.arready = 1'b0;
        ar_q.push_back(mk_ar(1, 32'h700, 0));
        ar_q.push_back(mk_ar(0, 32'h710, 1));
        fork
            send_ar(1, 4'd7, 32'h700);
            begin @(posedge ACLK); #1 send_ar(0, 4'd8, 32'h710); end
            begin
                repeat (2) @(negedge ACLK);
                repeat (5) begin
                    @(negedge ACLK);
                    chk("t32_hold_addr", dn_ar_m.araddr, 32'h700);
                    chk("t32_hold_valid", dn_ar_m.arvalid, 1);
                    chk("t32_port0_ready", up_ar_s[0].arready, 0);
                end
                @(posedge ACLK); #1 dn_ar_s.arready = 1'b1;
            end
        join
        r_q.push_back(mk_r(1, 4'd7, 32'hB0, 1'b1));
        r_q.push_back(mk_r(0, 4'd8, 32'hB1, 1'b1));
        send_r(32'hB0, 1'b1, 0);
        send_r(32'hB1, 1'b1, 1);

        // fill the 4-entry FIFO, 5th waits for a pop
        ar_q.push_back(mk_ar(0, 32'h400, 0));
        for (int i = 1; i < 4; i++) ar_q.push_back(mk_ar(0, 32'h400 + 4 * i, 1));
        for (int i = 0; i < 4; i++) send_ar(0, 4'(i), 32'h400 + 4 * i);
        ar_q.push_back(mk_ar(0, 32'h410, 2));
        r_q.push_back(mk_r(0, 4'd0, 32'hC0, 1'b1));
        fork
            send_ar(0, 4'd4, 32'h410);
            begin
                repeat (6) begin
                    @(negedge ACLK);
                    chk("t33_full_no_ar", dn_ar_m.arvalid, 0);
                end
                @(posedge ACLK); #1 send_r(32'hC0, 1'b1, -1);
            end
        join
        for (int i = 1; i < 5; i++) r_q.push_back(mk_r(0, 4'(i), 32'hC0 + i, 1'b1));
        for (int i = 1; i < 5; i++) send_r(32'hC0 + i, 1'b1, -1);

        // in-order routing between ports with original IDs
        ar_q.push_back(mk_ar(0, 32'h500, 0));
        ar_q.push_back(mk_ar(1, 32'h600, 0));
        send_ar(0, 4'd9, 32'h500);
        send_ar(1, 4'hA, 32'h600);
        for (int i = 0; i < 3; i++) r_q.push_back(mk_r(0, 4'd9, 32'hE0 + i, i == 2));
        for (int i = 0; i < 2; i++) r_q.push_back(mk_r(1, 4'hA, 32'hF0 + i, i == 1));
        for (int i = 0; i < 3; i++) send_r(32'hE0 + i, i == 2, 1);
        for (int i = 0; i < 2; i++) send_r(32'hF0 + i, i == 1, 0);

        // orphan beat with empty FIFO
        dn_r_s.rvalid = 1'b1;
        dn_r_s.rlast  = 1'b1;
        @(negedge ACLK);
        chk("t35_orphan_rready", dn_r_m.rready, 0);
        chk("t35_orphan_rvalid_up", up_r_s[0].rvalid, 0);
        chk("t35_orphan_before", orphan, 0);
        @(posedge ACLK); #1;
        chk("t35_orphan_set", orphan, 1);
        dn_r_s.rvalid = 1'b0;
        dn_r_s.rlast  = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 chk("t35_orphan_sticky", orphan, 1);

        // reset in the middle of a burst
        ar_q.push_back(mk_ar(0, 32'h800, 0));
        send_ar(0, 4'hB, 32'h800);
        r_q.push_back(mk_r(0, 4'hB, 32'h1234, 1'b0));
        send_r(32'h1234, 1'b0, 1);
        dn_r_s.rvalid = 1'b1;
        dn_r_s.rdata  = 32'h5678;
        #2 chk("t35_midburst_rvalid", up_r_s[0].rvalid, 1);
        #1 ARESETn = 1'b0;
        #1 chk_all_zero("t35_reset");
        dn_r_s.rvalid = 1'b0;
        @(posedge ACLK); #1 ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 chk_all_zero("t35_after_reset");

        chk("ar_queue_drained", ar_q.size(), 0);
        chk("r_queue_drained", r_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_axi_rd_arb.md
RISCV_AXI_RD_ARB -- requirements
Module: riscv_axi_rd_arb

Interface
REQ-001 Parameter N_PORTS, 2, number of upstream AXI4 read ports (index 0 = LSU, 1 = IFU); legal 2..8.
REQ-002 Parameter DEPTH, 4, outstanding-read tracking FIFO depth; power of two, 2..16.
REQ-003 ACLK  input  1  sole clock; all state on rising edge.
REQ-004 ARESETn  input  1  asynchronous, active-low reset.
REQ-005 UP_AR_M  input  axi4_pkg::ar_m [N_PORTS-1:0]  upstream read-address requests (ARVALID, ARID, ARADDR, ...).
REQ-006 UP_AR_S  output  axi4_pkg::ar_s [N_PORTS-1:0]  upstream ARREADY per port.
REQ-007 UP_R_M  input  axi4_pkg::r_m [N_PORTS-1:0]  upstream RREADY per port.
REQ-008 UP_R_S  output  axi4_pkg::r_s [N_PORTS-1:0]  upstream read data (RVALID, RID, RDATA, RRESP, RLAST).
REQ-009 DN_AR_M  output  axi4_pkg::ar_m  merged read-address channel to memory.
REQ-010 DN_AR_S  input  axi4_pkg::ar_s  downstream ARREADY.
REQ-011 DN_R_S  input  axi4_pkg::r_s  downstream read data.
REQ-012 DN_R_M  output  axi4_pkg::r_m  downstream RREADY.
REQ-013 ORPHAN_ERR  output  1  sticky: downstream RVALID seen with tracking FIFO empty.

Function
REQ-014 AR state machine SHALL have states IDLE and ISSUE; reset state IDLE.
REQ-015 IDLE: if any UP_AR_M[i].ARVALID and FIFO not full, SHALL register round-robin winner (search starts at last_grant+1, wraps at N_PORTS-1 to 0) and go ISSUE next cycle; otherwise stay IDLE.
REQ-016 ISSUE: DN_AR_M SHALL equal UP_AR_M[grant] with ARVALID=1 and ARID forced to 0; UP_AR_S[grant].ARREADY SHALL equal DN_AR_S.ARREADY; all other upstream ARREADY SHALL be 0.
REQ-017 IDLE: DN_AR_M.ARVALID and every UP_AR_S[i].ARREADY SHALL be 0.
REQ-018 On DN AR handshake in ISSUE: push {grant, original ARID} into FIFO, last_grant<=grant, return to IDLE; minimum AR issue interval 2 cycles.
REQ-019 Grant SHALL not change while in ISSUE, regardless of other ports' ARVALID.
REQ-020 R path combinational: when FIFO non-empty with head port h, UP_R_S[h] SHALL equal DN_R_S with RID replaced by stored ARID; DN_R_M.RREADY SHALL equal UP_R_M[h].RREADY.
REQ-021 UP_R_S[i].RVALID SHALL be 0 for all i != h, and for all i when FIFO empty.
REQ-022 FIFO SHALL pop on DN R handshake with RLAST=1; non-last beats SHALL not pop.
REQ-023 Push and pop in same cycle SHALL both take effect; count unchanged.
REQ-024 Full gating uses current count only: when count==DEPTH, IDLE SHALL not grant even if a pop occurs that cycle.
REQ-025 FIFO pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-026 FIFO empty with DN_R_S.RVALID=1: DN_R_M.RREADY SHALL be 0 and ORPHAN_ERR SHALL set next cycle and hold until reset.

Reset
REQ-027 ARESETn low SHALL immediately force: state IDLE, last_grant=N_PORTS-1, FIFO count and pointers 0, ORPHAN_ERR 0.
REQ-028 During and after reset, all ARVALID/ARREADY/RVALID/RREADY outputs SHALL be 0 until a new grant or FIFO entry exists.
REQ-029 Reset mid-transaction SHALL discard all outstanding entries; downstream memory is reset on the same ARESETn.

Verification
REQ-030 Port0 ARVALID ARID=3 ADDR=0x100, DN ARREADY=1 -> DN ARVALID on cycle 2 with ARID=0; one 4-beat burst -> port0 gets 4 beats RID=3, FIFO pops on 4th.
REQ-031 Both ports ARVALID continuously, ARREADY=1 -> grants alternate 0,1,0,1 (after reset first grant is port 0), one AR per 2 cycles.
REQ-032 Port1 in ISSUE with DN ARREADY=0 for 5 cycles while port0 asserts ARVALID -> grant stays 1, port0 ARREADY stays 0.
REQ-033 DEPTH=4, issue 4 ARs with R withheld -> 5th not granted; return one RLAST -> 5th issues 2 cycles later.
REQ-034 ARs from port0 then port1, responses in order -> data routed 0 then 1 with original RIDs; port1 sees RVALID=0 during port0 burst.
REQ-035 DN RVALID with FIFO empty -> RREADY=0, ORPHAN_ERR=1 next cycle; ARESETn pulse low mid-burst -> all outputs 0 immediately, ORPHAN_ERR cleared.
